keyboard_note_player: RTL



---
 rtl/keyboard_note_player_if.sv | 10 +
 rtl/keyboard_note_player.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/keyboard_note_player_if.sv
// Key-event bus from the PS/2 keycode recognizer into the note player.
interface keyboard_note_player_if;
  logic       keycode_ready;
  logic [7:0] keycode;
  logic       make;
  logic       ext;

  modport master (output keycode_ready, output keycode, output make, output ext);
  modport slave  (input  keycode_ready, input  keycode, input  make, input  ext);
endinterface

// File: rtl/keyboard_note_player.sv
// Maps PS/2 key events to a square-wave half-period using a last-note-priority
// stack of held keys, an octave offset and a minimum audible note duration.
module keyboard_note_player #(
  parameter int unsigned STACK_DEPTH     = 4,
  parameter int unsigned MIN_HOLD_CYCLES = 2500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  keyboard_note_player_if.slave   kbd,
  output logic [19:0]             note,
  output logic                    gate,
  output logic [2:0]              stack_count,
  output logic signed [2:0]       octave
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned HW = (MIN_HOLD_CYCLES > 1) ? $clog2(MIN_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_HOLD_CYCLES - 1);
  localparam logic [7:0] KEY_Z = 8'h1A;
  localparam logic [7:0] KEY_X = 8'h22;

  function automatic logic [19:0] base_of(input logic [7:0] code);
    case (code)
      8'h1C:   base_of = 20'd95555;
      8'h1B:   base_of = 20'd85131;
      8'h23:   base_of = 20'd75843;
      8'h2B:   base_of = 20'd71586;
      8'h34:   base_of = 20'd63776;
      8'h33:   base_of = 20'd56818;
      8'h3B:   base_of = 20'd50619;
      8'h42:   base_of = 20'd47778;
      default: base_of = 20'd0;
    endcase
  endfunction

  logic [7:0]        stk_q [STACK_DEPTH];
  logic [7:0]        stk_d [STACK_DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic signed [2:0] oct_d;
  logic              pushed_q, pushed_d;
  logic [HW-1:0]     hold_q, hold_dec;
  logic [19:0]       top_base, target;
  logic              is_note, found;
  int                idx, cnt_i;

  // Stack and octave update for one accepted key event.
  always_comb begin
    stk_d    = stk_q;
    cnt_d    = cnt_q;
    oct_d    = octave;
    pushed_d = 1'b0;
    found    = 1'b0;
    idx      = 0;
    cnt_i    = int'(cnt_q);
    is_note  = (base_of(kbd.keycode) != 20'd0);
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (i < cnt_i && stk_q[i] == kbd.keycode) begin
        found = 1'b1;
        idx   = i;
      end
    end
    if (kbd.keycode_ready && !kbd.ext) begin
      if (is_note && kbd.make) begin
        if (!(found && idx == cnt_i - 1)) begin
          pushed_d = 1'b1;
          if (found) begin
            for (int i = 0; i < int'(STACK_DEPTH) - 1; i++)
              if (i >= idx && i < cnt_i - 1) stk_d[i] = stk_q[i+1];
            for (int i = 0; i < int'(STACK_DEPTH); i++)
              if (i == cnt_i - 1) stk_d[i] = kbd.keycode;
          end else if (cnt_i == int'(STACK_DEPTH)) begin
            // Full: oldest entry falls off the bottom.
            for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) stk_d[i] = stk_q[i+1];
            stk_d[STACK_DEPTH-1] = kbd.keycode;
          end else begin
            for (int i = 0; i < int'(STACK_DEPTH); i++)
              if (i == cnt_i) stk_d[i] = kbd.keycode;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end else if (is_note && found) begin
        for (int i = 0; i < int'(STACK_DEPTH) - 1; i++)
          if (i >= idx) stk_d[i] = stk_q[i+1];
        cnt_d = cnt_q - CW'(1);
      end else if (kbd.make && kbd.keycode == KEY_Z && octave != -3'sd2) begin
        oct_d = octave - 3'sd1;
      end else if (kbd.make && kbd.keycode == KEY_X && octave != 3'sd2) begin
        oct_d = octave + 3'sd1;
      end
    end
  end

  // Half-period of the newest held key, shifted by the octave offset.
  always_comb begin
    top_base = 20'd0;
    for (int i = 0; i < int'(STACK_DEPTH); i++)
      if (i + 1 == int'(cnt_q)) top_base = base_of(stk_q[i]);
    case (octave)
      3'b001:  target = top_base >> 1;
      3'b010:  target = top_base >> 2;
      3'b111:  target = top_base << 1;
      3'b110:  target = top_base << 2;
      default: target = top_base;
    endcase
    hold_dec = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) stk_q[i] <= 8'h00;
      cnt_q    <= '0;
      octave   <= 3'sd0;
      pushed_q <= 1'b0;
      hold_q   <= '0;
      note     <= 20'd0;
      gate     <= 1'b0;
    end else begin
      stk_q    <= stk_d;
      cnt_q    <= cnt_d;
      octave   <= oct_d;
      pushed_q <= pushed_d;
      if (target != 20'd0 && target != note) begin
        note <= target;
        gate <= 1'b1;
        // Octave retune of a sounding note keeps the running hold.
        if (pushed_q || note == 20'd0) hold_q <= HOLD_INIT;
        else                           hold_q <= hold_dec;
      end else begin
        if (target == 20'd0 && hold_q == '0) begin
          note <= 20'd0;
          gate <= 1'b0;
        end
        hold_q <= hold_dec;
      end
    end
  end

  assign stack_count = 3'(cnt_q);

endmodule
